// File: rtl/mem_ctrl_pkg.sv
// Shared types and encodings for the MEM-stage data-memory access controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts BUSY cycles spent waiting on memory; tc flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic CLR,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Turns a one-cycle EX/MEM memory request into an issue/wait/complete handshake
// with data memory, stalling upstream while the access is outstanding.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              enable_i,
  input  logic              rw_i,
  input  logic              size_i,
  input  logic              load_i,
  input  logic              rf_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_en_o,
  output logic              mem_rw_o,
  output logic              mem_size_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              load_o,
  output logic              rf_o,
  output logic              fault_o
);

  state_t state;
  logic   load_q;
  logic   rf_q;
  logic   misaligned;
  logic   timer_tc;

  assign misaligned = enable_i & (size_i == SIZE_WORD) & (addr_i[1:0] != 2'b00);

  // DONE releases the stall so EX/MEM advances on the same edge the result retires.
  assign stall_o = (state == BUSY) | ((state == IDLE) & enable_i & ~misaligned);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK    (CLK),
    .CLR    (CLR),
    .clear  (state != BUSY),
    .enable ((state == BUSY) & ~mem_ready_i),
    .tc     (timer_tc)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state       <= IDLE;
      mem_en_o    <= 1'b0;
      mem_rw_o    <= 1'b0;
      mem_size_o  <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      load_q      <= 1'b0;
      rf_q        <= 1'b0;
      done_o      <= 1'b0;
      rdata_o     <= '0;
      load_o      <= 1'b0;
      rf_o        <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      fault_o <= 1'b0;
      load_o  <= 1'b0;
      rf_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (misaligned) begin
            fault_o <= 1'b1;
          end else if (enable_i) begin
            mem_en_o    <= 1'b1;
            mem_rw_o    <= rw_i;
            mem_size_o  <= size_i;
            mem_addr_o  <= addr_i;
            mem_wdata_o <= wdata_i;
            load_q      <= load_i;
            rf_q        <= rf_i;
            state       <= BUSY;
          end
        end
        BUSY: begin
          // Ready takes priority over a timeout in the same cycle.
          if (mem_ready_i) begin
            if (mem_rw_o == RW_WRITE)
              rdata_o <= '0;
            else if (mem_size_o == SIZE_BYTE)
              rdata_o <= {{(DATA_W-8){1'b0}}, mem_rdata_i[7:0]};
            else
              rdata_o <= mem_rdata_i;
            mem_en_o <= 1'b0;
            done_o   <= 1'b1;
            load_o   <= load_q;
            rf_o     <= rf_q;
            state    <= DONE;
          end else if (timer_tc) begin
            mem_en_o <= 1'b0;
            fault_o  <= 1'b1;
            state    <= IDLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: handshake latency, byte/word data, misalign, timeout, reset abort.
module tb_mem_access_ctrl;

  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              CLR = 1'b1;
  logic              enable_i = 1'b0;
  logic              rw_i = 1'b0;
  logic              size_i = 1'b0;
  logic              load_i = 1'b0;
  logic              rf_i = 1'b0;
  logic [DATA_W-1:0] addr_i = '0;
  logic [DATA_W-1:0] wdata_i = '0;
  logic              mem_ready_i = 1'b0;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              mem_en_o, mem_rw_o, mem_size_o;
  logic [DATA_W-1:0] mem_addr_o, mem_wdata_o, rdata_o;
  logic              stall_o, done_o, load_o, rf_o, fault_o;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_access_ctrl #(.DATA_W(DATA_W), .TIMEOUT(16)) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .enable_i    (enable_i),
    .rw_i        (rw_i),
    .size_i      (size_i),
    .load_i      (load_i),
    .rf_i        (rf_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_en_o    (mem_en_o),
    .mem_rw_o    (mem_rw_o),
    .mem_size_o  (mem_size_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .load_o      (load_o),
    .rf_o        (rf_o),
    .fault_o     (fault_o)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic request(input logic rw, input logic sz, input logic [DATA_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input logic ld, input logic rf);
    enable_i = 1'b1; rw_i = rw; size_i = sz; addr_i = addr; wdata_i = wd; load_i = ld; rf_i = rf;
  endtask

  task automatic idle_inputs();
    enable_i = 1'b0; rw_i = 1'b0; size_i = 1'b0; addr_i = '0; wdata_i = '0; load_i = 1'b0; rf_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_mem_en", mem_en_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_done", done_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_addr", mem_addr_o, 0);
    tick();
    CLR = 1'b0;
    tick();

    // Ready outside BUSY is ignored
    mem_ready_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    tick();
    check("idle_ready_done", done_o, 0);
    check("idle_ready_en", mem_en_o, 0);
    mem_ready_i = 1'b0;

    // Word read 0x100, ready in first BUSY cycle
    request(1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 1'b1);
    #1 check("wr0_stall_c0", stall_o, 1);
    check("wr0_en_c0", mem_en_o, 0);
    tick();
    idle_inputs();
    mem_ready_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1 check("wr0_stall_c1", stall_o, 1);
    check("wr0_en_c1", mem_en_o, 1);
    check("wr0_addr", mem_addr_o, 32'h100);
    check("wr0_rw", mem_rw_o, 0);
    check("wr0_size", mem_size_o, 1);
    tick();
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    check("wr0_done", done_o, 1);
    check("wr0_rdata", rdata_o, 32'hDEAD_BEEF);
    check("wr0_load", load_o, 1);
    check("wr0_rf", rf_o, 1);
    check("wr0_stall_c2", stall_o, 0);
    check("wr0_en_c2", mem_en_o, 0);
    tick();
    check("wr0_done_drop", done_o, 0);

    // Byte read 0x103, three wait cycles, then ready
    request(1'b0, 1'b0, 32'h103, 32'h0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check("br_wait_en", mem_en_o, 1);
      check("br_wait_stall", stall_o, 1);
      check("br_wait_done", done_o, 0);
      tick();
    end
    mem_ready_i = 1'b1; mem_rdata_i = 32'hAABB_CCDD;
    tick();
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    check("br_done", done_o, 1);
    check("br_rdata", rdata_o, 32'h0000_00DD);
    check("br_load", load_o, 1);
    check("br_rf", rf_o, 0);
    check("br_fault", fault_o, 0);
    tick();

    // Misaligned word write 0x102
    request(1'b1, 1'b1, 32'h102, 32'hCAFE_F00D, 1'b0, 1'b0);
    #1 check("mis_stall", stall_o, 0);
    tick();
    idle_inputs();
    check("mis_fault", fault_o, 1);
    check("mis_en", mem_en_o, 0);
    check("mis_done", done_o, 0);
    tick();
    check("mis_fault_drop", fault_o, 0);
    check("mis_en_after", mem_en_o, 0);

    // Write with ready held low: timeout after 16 BUSY cycles
    request(1'b1, 1'b1, 32'h200, 32'h5555_AAAA, 1'b0, 1'b0);
    tick();
    idle_inputs();
    check("to_wdata", mem_wdata_o, 32'h5555_AAAA);
    check("to_rw", mem_rw_o, 1);
    for (int i = 0; i < 16; i++) begin
      check("to_busy_en", mem_en_o, 1);
      check("to_busy_fault", fault_o, 0);
      check("to_busy_done", done_o, 0);
      tick();
    end
    check("to_fault", fault_o, 1);
    check("to_en", mem_en_o, 0);
    check("to_done", done_o, 0);
    check("to_stall", stall_o, 0);
    tick();
    check("to_fault_drop", fault_o, 0);
    check("to_done_after", done_o, 0);

    // Write completing normally returns rdata 0
    request(1'b1, 1'b1, 32'h204, 32'h1111_2222, 1'b0, 1'b0);
    tick();
    idle_inputs();
    mem_ready_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    tick();
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    check("wr_done", done_o, 1);
    check("wr_rdata", rdata_o, 0);
    tick();

    // Reset asserted mid-BUSY aborts the access immediately
    request(1'b0, 1'b1, 32'h240, 32'h0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    check("clr_pre_en", mem_en_o, 1);
    CLR = 1'b1;
    #1 check("clr_en", mem_en_o, 0);
    check("clr_stall", stall_o, 0);
    check("clr_addr", mem_addr_o, 0);
    tick();
    check("clr_done", done_o, 0);
    check("clr_fault", fault_o, 0);
    CLR = 1'b0;
    tick();
    request(1'b0, 1'b1, 32'h300, 32'h0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    check("post_clr_addr", mem_addr_o, 32'h300);
    mem_ready_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D;
    tick();
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    check("post_clr_done", done_o, 1);
    check("post_clr_rdata", rdata_o, 32'h0BAD_F00D);
    tick();

    // Back-to-back loads: enable in DONE belongs to the retiring load
    request(1'b0, 1'b1, 32'h400, 32'h0, 1'b1, 1'b1);
    tick();
    mem_ready_i = 1'b1; mem_rdata_i = 32'h4444_4444;
    tick();
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    check("b2b_done_a", done_o, 1);
    check("b2b_rdata_a", rdata_o, 32'h4444_4444);
    #1 check("b2b_done_stall", stall_o, 0);
    tick();
    request(1'b0, 1'b1, 32'h500, 32'h0, 1'b1, 1'b0);
    #1 check("b2b_idle_en", mem_en_o, 0);
    check("b2b_idle_stall", stall_o, 1);
    check("b2b_idle_done", done_o, 0);
    tick();
    idle_inputs();
    check("b2b_issue_en", mem_en_o, 1);
    check("b2b_issue_addr", mem_addr_o, 32'h500);
    mem_ready_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    tick();
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    check("b2b_done_b", done_o, 1);
    check("b2b_rdata_b", rdata_o, 32'h5555_5555);
    check("b2b_rf_b", rf_o, 0);
    tick();
    check("b2b_final_en", mem_en_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
